// File: rtl/keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_lock_ctrl
// Purpose  : Keypad door-lock controller. It handles password enrolment with
//            re-entry verification, lock/unlock, lockout after repeated
//            failures, and recovery through a fixed master code.
// Ports    : clk            - single rising-edge clock
//            rstn           - asynchronous active-low reset
//            digit_buttons  - debounced digit keys, bit d = digit d
//            confirm_button - debounced confirm/lock key
//            locked         - bolt engaged (LOCKED or LOCKOUT)
//            state          - FSM state code (SET=0 VERIFY=1 OPEN=2
//                             LOCKED=3 LOCKOUT=4)
//            entry_len      - digits currently held in the entry buffer
//            fail_count     - consecutive failed unlock attempts
// Revision : 1.0 - initial release
// ============================================================================
module keypad_lock_ctrl #(
    parameter int                        MIN_DIGITS        = 4,
    parameter int                        MAX_DIGITS        = 8,
    parameter int                        MAX_FAILS         = 5,
    parameter int                        LOCKOUT_CYCLES    = 200,
    parameter int                        LONG_PRESS_CYCLES = 20,
    parameter int                        MASTER_LEN        = 4,
    parameter logic [MAX_DIGITS*4-1:0]   MASTER_CODE       = 'h2718
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [9:0]                         digit_buttons,
    input  logic                               confirm_button,
    output logic                               locked,
    output logic [2:0]                         state,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    entry_len,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

    localparam int ENTRY_W = MAX_DIGITS * 4;
    localparam int LEN_W   = $clog2(MAX_DIGITS + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int HOLD_W  = $clog2(LONG_PRESS_CYCLES + 1);

    // Only the MASTER_LEN low nibbles of the master code are meaningful.
    function automatic logic [ENTRY_W-1:0] f_master_mask();
        logic [ENTRY_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < MASTER_LEN) m[i*4 +: 4] = 4'hF;
        end
        return m;
    endfunction

    localparam logic [ENTRY_W-1:0] c_master     = MASTER_CODE & f_master_mask();
    localparam logic [LEN_W-1:0]   c_master_len = LEN_W'(MASTER_LEN);
    localparam logic [LEN_W-1:0]   c_min_len    = LEN_W'(MIN_DIGITS);
    localparam logic [LEN_W-1:0]   c_max_len    = LEN_W'(MAX_DIGITS);
    localparam logic [FAIL_W-1:0]  c_max_fails  = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]   c_lockout    = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [HOLD_W-1:0]  c_long       = HOLD_W'(LONG_PRESS_CYCLES);

    typedef enum logic [2:0] {
        ST_SET     = 3'd0,
        ST_VERIFY  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [9:0]          r_dig_q;
    logic                r_conf_q;
    logic [ENTRY_W-1:0]  r_entry,     w_entry_nxt;
    logic [LEN_W-1:0]    r_entry_len, w_entry_len_nxt;
    logic [ENTRY_W-1:0]  r_cand,      w_cand_nxt;
    logic [LEN_W-1:0]    r_cand_len,  w_cand_len_nxt;
    logic [ENTRY_W-1:0]  r_pass,      w_pass_nxt;
    logic [LEN_W-1:0]    r_pass_len,  w_pass_len_nxt;
    logic [FAIL_W-1:0]   r_fail,      w_fail_nxt;
    logic [TMR_W-1:0]    r_timer,     w_timer_nxt;
    logic                r_hold_act,  w_hold_act_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt,  w_hold_cnt_nxt;

    logic [9:0]          w_dig_rise;
    logic                w_conf_rise;
    logic                w_one_digit;
    logic [3:0]          w_dig_val;
    logic                w_match_cand;
    logic                w_match_pass;
    logic                w_match_master;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic [HOLD_W-1:0]   w_hold_inc;

    // ---------------------------------------------------------------- events
    assign w_dig_rise  = digit_buttons & ~r_dig_q;
    assign w_conf_rise = confirm_button & ~r_conf_q;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_one_digit = (w_dig_rise != 10'd0) &&
                         ((w_dig_rise & (w_dig_rise - 10'd1)) == 10'd0);

    always_comb begin
        w_dig_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_dig_rise[i]) w_dig_val = 4'(i);
        end
    end

    // Unused high nibbles of the entry are always zero, so a full-vector
    // compare plus a length compare implements the match rule.
    assign w_match_cand   = (r_entry_len == r_cand_len)   && (r_entry == r_cand);
    assign w_match_pass   = (r_entry_len == r_pass_len)   && (r_entry == r_pass);
    assign w_match_master = (r_entry_len == c_master_len) && (r_entry == c_master);
    assign w_fail_inc     = r_fail + FAIL_W'(1);
    assign w_hold_inc     = r_hold_cnt + HOLD_W'(1);

    // ------------------------------------------------------------ next state
    always_comb begin
        w_state_nxt     = r_state;
        w_entry_nxt     = r_entry;
        w_entry_len_nxt = r_entry_len;
        w_cand_nxt      = r_cand;
        w_cand_len_nxt  = r_cand_len;
        w_pass_nxt      = r_pass;
        w_pass_len_nxt  = r_pass_len;
        w_fail_nxt      = r_fail;
        w_timer_nxt     = r_timer;
        w_hold_act_nxt  = r_hold_act;
        w_hold_cnt_nxt  = r_hold_cnt;

        case (r_state)
            ST_SET: begin
                if (w_conf_rise && (r_entry_len >= c_min_len)) begin
                    w_cand_nxt     = r_entry;
                    w_cand_len_nxt = r_entry_len;
                    w_state_nxt    = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (w_conf_rise) begin
                    if (w_match_cand) begin
                        w_pass_nxt     = r_cand;
                        w_pass_len_nxt = r_cand_len;
                        w_state_nxt    = ST_OPEN;
                    end else begin
                        w_cand_nxt     = '0;
                        w_cand_len_nxt = '0;
                        w_state_nxt    = ST_SET;
                    end
                end
            end
            ST_OPEN: begin
                // A press held over from the previous state never arms the
                // hold measurement; only a rise seen here does.
                if (r_hold_act) begin
                    if (!confirm_button) begin
                        w_state_nxt = ST_LOCKED;
                    end else if (w_hold_inc == c_long) begin
                        w_state_nxt = ST_SET;
                    end else begin
                        w_hold_cnt_nxt = w_hold_inc;
                    end
                end else if (w_conf_rise) begin
                    w_hold_act_nxt = 1'b1;
                    w_hold_cnt_nxt = HOLD_W'(1);
                    if (c_long == HOLD_W'(1)) w_state_nxt = ST_SET;
                end
            end
            ST_LOCKED: begin
                if (w_conf_rise) begin
                    if (w_match_pass || w_match_master) begin
                        w_fail_nxt  = '0;
                        w_state_nxt = ST_OPEN;
                    end else begin
                        w_fail_nxt = w_fail_inc;
                        if (w_fail_inc == c_max_fails) begin
                            w_timer_nxt = c_lockout;
                            w_state_nxt = ST_LOCKOUT;
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                // Timer holds LOCKOUT_CYCLES on entry and counts down to 0;
                // LOCKED follows on the edge after it reads 0.
                if (w_conf_rise && w_match_master) begin
                    w_fail_nxt  = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_OPEN;
                end else if (r_timer == '0) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_SET;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_hold_act_nxt = 1'b0;
            w_hold_cnt_nxt = '0;
        end

        // A confirm in the same cycle as a digit wins: the clear drops it.
        if ((w_state_nxt != r_state) || w_conf_rise) begin
            w_entry_nxt     = '0;
            w_entry_len_nxt = '0;
        end else if (w_one_digit && (r_state != ST_OPEN) &&
                     (r_entry_len < c_max_len)) begin
            w_entry_nxt     = {r_entry[ENTRY_W-5:0], w_dig_val};
            w_entry_len_nxt = r_entry_len + LEN_W'(1);
        end
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_SET;
            r_dig_q     <= '0;
            r_conf_q    <= 1'b0;
            r_entry     <= '0;
            r_entry_len <= '0;
            r_cand      <= '0;
            r_cand_len  <= '0;
            r_pass      <= '0;
            r_pass_len  <= '0;
            r_fail      <= '0;
            r_timer     <= '0;
            r_hold_act  <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dig_q     <= digit_buttons;
            r_conf_q    <= confirm_button;
            r_entry     <= w_entry_nxt;
            r_entry_len <= w_entry_len_nxt;
            r_cand      <= w_cand_nxt;
            r_cand_len  <= w_cand_len_nxt;
            r_pass      <= w_pass_nxt;
            r_pass_len  <= w_pass_len_nxt;
            r_fail      <= w_fail_nxt;
            r_timer     <= w_timer_nxt;
            r_hold_act  <= w_hold_act_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    assign state      = r_state;
    assign locked     = (r_state == ST_LOCKED) || (r_state == ST_LOCKOUT);
    assign entry_len  = r_entry_len;
    assign fail_count = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_lock_ctrl
// Purpose  : Self-checking bench for keypad_lock_ctrl. A queue-based model of
//            the lock rules is stepped on every clock edge and compared with
//            all DUT outputs; directed sequences walk the main scenarios,
//            then random key actions exercise the rest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_lock_ctrl;

    localparam int MIN_D  = 4;
    localparam int MAX_D  = 8;
    localparam int MAX_F  = 5;
    localparam int LOCK_C = 200;
    localparam int LONG_C = 20;

    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] digit_buttons;
    logic       confirm_button;
    logic       locked;
    logic [2:0] state;
    logic [3:0] entry_len;
    logic [2:0] fail_count;

    keypad_lock_ctrl #(
        .MIN_DIGITS        (MIN_D),
        .MAX_DIGITS        (MAX_D),
        .MAX_FAILS         (MAX_F),
        .LOCKOUT_CYCLES    (LOCK_C),
        .LONG_PRESS_CYCLES (LONG_C),
        .MASTER_LEN        (4),
        .MASTER_CODE       (32'h2718)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .digit_buttons  (digit_buttons),
        .confirm_button (confirm_button),
        .locked         (locked),
        .state          (state),
        .entry_len      (entry_len),
        .fail_count     (fail_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_tick = 0;

    // ------------------------------------------------------------ model state
    int         m_state;
    int         m_entry[$];
    int         m_cand[$];
    int         m_pass[$];
    int         m_master[$];
    int         m_fail;
    int         m_lock_edges;
    bit         m_holding;
    int         m_hold;
    logic [9:0] m_prev_dig;
    bit         m_prev_conf;

    int pw_good[$];
    int pw_bad[$];
    int pw_near[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit q_eq(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_entry.delete();
        m_cand.delete();
        m_pass.delete();
        m_fail = 0;
        m_lock_edges = 0;
        m_holding = 1'b0;
        m_hold = 0;
        m_prev_dig = '0;
        m_prev_conf = 1'b0;
    endtask

    task automatic model_step();
        logic [9:0] rise;
        bit crise;
        int dval, old;
        rise  = digit_buttons & ~m_prev_dig;
        crise = confirm_button && !m_prev_conf;
        dval  = 0;
        for (int i = 0; i < 10; i++) if (rise[i]) dval = i;
        old = m_state;
        case (m_state)
            0: if (crise && m_entry.size() >= MIN_D) begin
                   m_cand = m_entry;
                   m_state = 1;
               end
            1: if (crise) begin
                   if (q_eq(m_entry, m_cand)) begin
                       m_pass = m_cand;
                       m_state = 2;
                   end else begin
                       m_cand.delete();
                       m_state = 0;
                   end
               end
            2: begin
                   if (m_holding) begin
                       if (!confirm_button) m_state = 3;
                       else begin
                           m_hold++;
                           if (m_hold == LONG_C) m_state = 0;
                       end
                   end else if (crise) begin
                       m_holding = 1'b1;
                       m_hold = 1;
                       if (LONG_C == 1) m_state = 0;
                   end
               end
            3: if (crise) begin
                   if (q_eq(m_entry, m_pass) || q_eq(m_entry, m_master)) begin
                       m_fail = 0;
                       m_state = 2;
                   end else begin
                       m_fail++;
                       if (m_fail == MAX_F) begin
                           m_state = 4;
                           m_lock_edges = 0;
                       end
                   end
               end
            4: begin
                   if (crise && q_eq(m_entry, m_master)) begin
                       m_fail = 0;
                       m_state = 2;
                   end else if (m_lock_edges == LOCK_C) begin
                       m_fail = 0;
                       m_state = 3;
                   end else begin
                       m_lock_edges++;
                   end
               end
            default: m_state = 0;
        endcase
        if (m_state != old) m_holding = 1'b0;
        if (m_state != old || crise) m_entry.delete();
        else if ($countones(rise) == 1 && old != 2 && m_entry.size() < MAX_D)
            m_entry.push_back(dval);
        m_prev_dig  = digit_buttons;
        m_prev_conf = confirm_button;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 32'(state), m_state);
        check({tag, "_locked"}, 32'(locked), (m_state >= 3) ? 1 : 0);
        check({tag, "_entry_len"}, 32'(entry_len), m_entry.size());
        check({tag, "_fail_count"}, 32'(fail_count), m_fail);
    endtask

    task automatic tick();
        @(posedge clk);
        n_tick++;
        if (!rstn) model_reset();
        else model_step();
        #1;
        check_all("cyc");
    endtask

    task automatic press_digit(input int d);
        digit_buttons = 10'(1 << d);
        tick();
        digit_buttons = '0;
        tick();
    endtask

    task automatic type_seq(input int q[$]);
        foreach (q[i]) press_digit(q[i]);
    endtask

    task automatic press_confirm(input int n);
        confirm_button = 1'b1;
        repeat (n) tick();
        confirm_button = 1'b0;
        tick();
    endtask

    task automatic enter(input int q[$]);
        type_seq(q);
        press_confirm(1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int q[$];
        pw_good  = '{6, 9, 6, 9};
        pw_bad   = '{1, 2, 3, 4};
        pw_near  = '{6, 9, 6, 8};
        m_master = '{2, 7, 1, 8};
        rstn = 1'b0;
        digit_buttons = '0;
        confirm_button = 1'b0;
        model_reset();
        #12;
        check("rst_state", 32'(state), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_entry_len", 32'(entry_len), 0);
        check("rst_fail_count", 32'(fail_count), 0);
        tick();
        rstn = 1'b1;
        tick();

        // Length limits
        type_seq('{1, 2, 3});
        press_confirm(1);
        check("short_pw_state", 32'(state), 0);
        check("short_pw_len", 32'(entry_len), 0);
        repeat (33) press_digit(0);
        check("saturate_len", 32'(entry_len), 8);
        press_confirm(1);
        check("max_len_verify", 32'(state), 1);
        press_confirm(1);
        check("verify_empty_set", 32'(state), 0);

        // Enrolment
        type_seq(pw_good);
        check("enrol_len", 32'(entry_len), 4);
        press_confirm(1);
        check("enrol_verify", 32'(state), 1);
        enter(pw_near);
        check("enrol_mismatch", 32'(state), 0);
        enter(pw_good);
        enter(pw_good);
        check("enrol_open", 32'(state), 2);
        check("enrol_unlocked", 32'(locked), 0);

        // Short hold of 10 cycles locks
        confirm_button = 1'b1;
        repeat (10) tick();
        check("hold10_still_open", 32'(state), 2);
        confirm_button = 1'b0;
        tick();
        check("short_lock_state", 32'(state), 3);
        check("short_lock_bolt", 32'(locked), 1);
        enter(pw_good);
        check("unlock_open", 32'(state), 2);

        // Long hold: SET on the 20th sampled-high edge
        confirm_button = 1'b1;
        repeat (LONG_C - 1) tick();
        check("long_19", 32'(state), 2);
        tick();
        check("long_20", 32'(state), 0);
        confirm_button = 1'b0;
        tick();
        check("long_release", 32'(state), 0);

        // Digit and confirm in the same cycle: confirm wins
        press_digit(4);
        digit_buttons = 10'h002;
        confirm_button = 1'b1;
        tick();
        check("dig_conf_len", 32'(entry_len), 0);
        digit_buttons = '0;
        confirm_button = 1'b0;
        tick();

        // Re-enrol and lock
        enter(pw_good);
        enter(pw_good);
        press_confirm(1);
        check("relock", 32'(state), 3);

        // Two digits rising together are dropped
        press_digit(1);
        digit_buttons = 10'b00_0010_1000;
        tick();
        check("multi_digit_len", 32'(entry_len), 1);
        digit_buttons = '0;
        tick();

        // Lockout entry and duration
        press_confirm(1);
        check("fail1", 32'(fail_count), 1);
        repeat (3) enter(pw_bad);
        check("fail4", 32'(fail_count), 4);
        type_seq(pw_bad);
        confirm_button = 1'b1;
        tick();
        t0 = n_tick;
        check("lockout_state", 32'(state), 4);
        check("lockout_fails", 32'(fail_count), 5);
        confirm_button = 1'b0;
        tick();
        enter(pw_good);
        check("lockout_user_pw", 32'(state), 4);
        check("lockout_fails_kept", 32'(fail_count), 5);
        while (state == 3'd4 && (n_tick - t0) < 400) tick();
        check("lockout_len", n_tick - t0, LOCK_C + 1);
        check("lockout_expire_state", 32'(state), 3);
        check("lockout_expire_fails", 32'(fail_count), 0);

        // Master recovery from lockout
        repeat (5) enter(pw_bad);
        check("lockout2", 32'(state), 4);
        enter(m_master);
        check("master_open", 32'(state), 2);
        check("master_fails", 32'(fail_count), 0);
        press_confirm(1);
        enter(pw_good);
        check("pw_after_master", 32'(state), 2);

        // Asynchronous reset mid-entry
        press_confirm(1);
        press_digit(7);
        press_digit(7);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check("arst_state", 32'(state), 0);
        check("arst_locked", 32'(locked), 0);
        check("arst_entry_len", 32'(entry_len), 0);
        check("arst_fail_count", 32'(fail_count), 0);
        tick();
        rstn = 1'b1;
        tick();

        // Randomised key actions
        for (int a = 0; a < 400; a++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3: press_digit($urandom_range(0, 9));
                4: begin
                    int b0, b1;
                    b0 = $urandom_range(0, 9);
                    b1 = (b0 + $urandom_range(1, 9)) % 10;
                    digit_buttons = 10'((1 << b0) | (1 << b1));
                    tick();
                    digit_buttons = '0;
                    tick();
                end
                5: press_confirm($urandom_range(1, 5));
                6: press_confirm($urandom_range(LONG_C - 2, LONG_C + 4));
                7: begin
                    if (m_state == 1) q = m_cand;
                    else if (m_pass.size() != 0 && $urandom_range(0, 1) == 1) q = m_pass;
                    else begin
                        q.delete();
                        repeat ($urandom_range(3, 9)) q.push_back($urandom_range(0, 9));
                    end
                    enter(q);
                end
                8: enter(m_master);
                9: begin
                    digit_buttons = 10'(1 << $urandom_range(0, 9));
                    confirm_button = 1'b1;
                    tick();
                    digit_buttons = '0;
                    confirm_button = 1'b0;
                    tick();
                end
                10: repeat ($urandom_range(1, 10)) tick();
                default: begin
                    if ($urandom_range(0, 15) == 0) begin
                        #2;
                        rstn = 1'b0;
                        #1;
                        model_reset();
                        check_all("rnd_arst");
                        tick();
                        rstn = 1'b1;
                    end
                    tick();
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Parametrised successor to the door-lock controller. Takes ten debounced digit buttons and one confirm button. Manages password enrolment with re-entry verification, locking and unlocking, and lockout after repeated failures. A master code, fixed at elaboration, recovers the lock from any locked state. It sits between the keypad debouncers and the bolt driver; `locked` drives the bolt directly.

## Interface
- `MIN_DIGITS`, 4, shortest password accepted at enrolment.
- `MAX_DIGITS`, 8, entry-buffer depth in digits; also the longest password.
- `MAX_FAILS`, 5, consecutive wrong entries in LOCKED that trigger LOCKOUT.
- `LOCKOUT_CYCLES`, 200, LOCKOUT duration in clk cycles.
- `LONG_PRESS_CYCLES`, 20, confirm hold length that counts as a long press.
- `MASTER_LEN`, 4, master code length in digits (1..MAX_DIGITS).
- `MASTER_CODE`, 'h2718, master code; one BCD nibble per digit, first digit in the most significant used nibble.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `digit_buttons` in 10: bit d high means digit d is pressed. Synchronous to clk, debounced upstream.
- `confirm_button` in 1: confirm/lock key. Synchronous to clk, debounced upstream.
- `locked` out 1: 1 means the bolt is engaged.
- `state` out 3: current FSM state code. SET=0, VERIFY=1, OPEN=2, LOCKED=3, LOCKOUT=4.
- `entry_len` out $clog2(MAX_DIGITS+1): number of digits currently held in the entry buffer.
- `fail_count` out $clog2(MAX_FAILS+1): consecutive failures counted so far.

## Operation
- Press events:
  - Registered copies of all 11 buttons feed the edge detector. event = raw & ~registered.
  - A digit event is accepted only if exactly one digit bit rises in that cycle. Multi-digit rises are dropped.
  - When a digit event and a confirm event occur in the same cycle, the confirm is processed and the digit is dropped.
- Entry buffer:
  - Holds MAX_DIGITS×4 bits; each accepted digit shifts in at the low end and `entry_len` increments.
  - At MAX_DIGITS the buffer saturates: further digits are ignored and the buffer contents are unchanged.
  - The buffer clears on every confirm event and on every state change.
- Match rule: lengths are equal and every nibble is equal. The master code is a match only against an entry of exactly MASTER_LEN digits.
- Reset state: SET. `locked`=0, buffer empty, stored password empty (length 0), `fail_count`=0, lockout timer 0.
- SET (`locked`=0):
  - Digits accumulate.
  - Confirm event with MIN_DIGITS ≤ `entry_len` ≤ MAX_DIGITS: copy the entry to the candidate register, go to VERIFY.
  - Confirm event with any other length: clear the buffer, stay in SET.
- VERIFY (`locked`=0):
  - Confirm event with an entry matching the candidate: commit it as the stored password, go to OPEN.
  - Confirm event with a mismatch: discard the candidate, go to SET.
- OPEN (`locked`=0):
  - Digits are ignored.
  - Hold-length measurement starts only on a confirm rising edge seen while in OPEN; a press already held on entry to OPEN is ignored until it is released.
  - Release before LONG_PRESS_CYCLES cycles of hold: go to LOCKED.
  - Hold reaching LONG_PRESS_CYCLES: go to SET on that cycle. The later release is ignored.
- LOCKED (`locked`=1):
  - Digits accumulate.
  - Confirm event matching the stored password or the master code: go to OPEN, clear `fail_count`.
  - Confirm event with no match: `fail_count`+1. When the new value equals MAX_FAILS, go to LOCKOUT and load the timer with LOCKOUT_CYCLES.
- LOCKOUT (`locked`=1):
  - The timer decrements every cycle.
  - Digits accumulate; only the master code is checked on a confirm event.
  - Master match: go to OPEN, clear `fail_count`, clear the timer.
  - Any other confirm: clear the buffer only; `fail_count` stays at MAX_FAILS.
  - Timer reaching 0: go to LOCKED, clear `fail_count`.
  - A master match and timer expiry in the same cycle: the master match wins.
- Reset mid-operation: returns every register to its reset value immediately and asynchronously, including the stored password.

## Timing
- Event latency: a press sampled high at rising edge k updates `state`, `locked`, `entry_len` and `fail_count` at edge k. Outputs are visible after edge k.
- All outputs are registered or decoded from `state`; no combinational path from the inputs to any output.
- Long press: the transition to SET occurs at the edge where the hold count (1 on the first sampled-high edge) equals LONG_PRESS_CYCLES.
- Lockout length: after the edge that enters LOCKOUT, exactly LOCKOUT_CYCLES further edges elapse before the edge that enters LOCKED.

## Test plan
- Enrolment: after reset enter 6,9,6,9, confirm → VERIFY. Enter 6,9,6,8, confirm → SET. Enrol 6,9,6,9 twice → OPEN, `locked`=0.
- Length limits: 3 digits then confirm → stays SET, `entry_len`=0. 33 presses of digit 0 → `entry_len`=8. Confirm → VERIFY.
- Press classification: in OPEN, confirm held 10 cycles → LOCKED. Enter 6969 and confirm → OPEN. Confirm held 20 cycles → SET at the 20th edge.
- Lockout: 5 wrong confirms in LOCKED → LOCKOUT, `fail_count`=5. Entering 6969 and confirming leaves it in LOCKOUT. After 200 cycles → LOCKED, `fail_count`=0.
- Master recovery: in LOCKOUT enter 2,7,1,8 and confirm → OPEN. Lock again; 6969 still opens.
- Edge cases: digits 3 and 5 rising in the same cycle → `entry_len` unchanged. Deasserting `rstn` mid-entry → SET, all outputs at reset values, stored password cleared.
